lsu_align: RTL and testbench

Memory-stage load/store aligner sitting directly upstream of the data memory. It converts a pipeline load/store request (byte address, funct3, store data) into word-addressed accesses with byte strobes, and returns a sign-/zero-extended load result. Accesses that cross a 32-bit word boundary are split into two back-to-back word accesses under a two-state FSM that stalls the pipeline for one extra cycle. The downstream memory reads combinationally and writes on the rising clock edge when its enable is high and any strobe is set.

---
 rtl/lsu_align.sv | 143 ++++++++++++++
 tb/tb_lsu_align.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// Load/store aligner between the pipeline and a word-wide data memory.
// Word-crossing accesses are split into two back-to-back word accesses with a one-cycle stall.
module lsu_align #(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_datai,
    input  logic [31:0] mem_datao,
    output logic        mem_ce,
    output logic [3:0]  mem_wstb
);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t      state_q, state_d;
    logic [31:0] lo_q, lo_d;

    logic [1:0]  offset;
    logic [4:0]  shamt;
    logic [1:0]  size;
    logic        legal;
    logic        crossing;
    logic [3:0]  mask;
    logic [7:0]  strb_wide;
    logic [63:0] data_wide;
    logic [63:0] load_src;
    logic [31:0] load_raw;
    logic [31:0] load_val;

    // Sign/zero extension of the lane-aligned load word according to the width code.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = raw[7:0];
        h = raw[15:0];
        case (f3)
            3'd0:    r = b;
            3'd1:    r = h;
            3'd4:    r = {24'd0, raw[7:0]};
            3'd5:    r = {16'd0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign offset    = addr[1:0];
    assign shamt     = {offset, 3'b000};
    assign size      = funct3[1:0];
    assign legal     = we ? (funct3 < 3'd3)
                          : (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7);
    assign crossing  = (size == 2'd1 && offset == 2'd3) || (size == 2'd2 && offset != 2'd0);

    always_comb begin
        case (size)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    // Low nibble/word feeds the first access, high nibble/word the second.
    assign strb_wide = {4'b0000, mask} << offset;
    assign data_wide = {32'd0, wdata} << shamt;
    assign load_src  = (state_q == SECOND) ? {mem_datao, lo_q} : {32'd0, mem_datao};
    assign load_raw  = 32'(load_src >> shamt);
    assign load_val  = extend(load_raw, funct3);

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        rdata     = 32'd0;
        done      = 1'b0;
        stall     = 1'b0;
        err       = 1'b0;
        mem_addr  = 30'd0;
        mem_datai = 32'd0;
        mem_ce    = 1'b0;
        mem_wstb  = 4'b0000;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (!legal || (crossing && !MISALIGN_EN)) begin
                            done = 1'b1;
                            err  = 1'b1;
                        end else begin
                            mem_ce   = 1'b1;
                            mem_addr = addr[31:2];
                            if (we) begin
                                mem_wstb  = strb_wide[3:0];
                                mem_datai = data_wide[31:0];
                            end
                            if (crossing) begin
                                stall   = 1'b1;
                                state_d = SECOND;
                                if (!we) lo_d = mem_datao;
                            end else begin
                                done = 1'b1;
                                if (!we) rdata = load_val;
                            end
                        end
                    end
                end
                SECOND: begin
                    mem_ce   = 1'b1;
                    mem_addr = addr[31:2] + 30'd1;
                    done     = 1'b1;
                    state_d  = IDLE;
                    if (we) begin
                        mem_wstb  = strb_wide[7:4];
                        mem_datai = data_wide[63:32];
                    end else begin
                        rdata = load_val;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: aligned, split, wrapping, error and reset-mid-split accesses
// against a small byte-lane memory model.
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        rst_n, req, req_nm, we, mem_clr;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;

    logic [31:0] rdata, mem_datai, mem_datao;
    logic        done, stall, err, mem_ce;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstb;

    logic [31:0] rdata_nm, mem_datai_nm, mem_datao_nm;
    logic        done_nm, stall_nm, err_nm, mem_ce_nm;
    logic [29:0] mem_addr_nm;
    logic [3:0]  mem_wstb_nm;

    logic [31:0] mem    [256];
    logic [31:0] mem_nm [256];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lsu_align #(.MISALIGN_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .stall(stall), .err(err),
        .mem_addr(mem_addr), .mem_datai(mem_datai), .mem_datao(mem_datao),
        .mem_ce(mem_ce), .mem_wstb(mem_wstb)
    );

    lsu_align #(.MISALIGN_EN(1'b0)) u_dut_nm (
        .clk(clk), .rst_n(rst_n), .req(req_nm), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata_nm), .done(done_nm), .stall(stall_nm), .err(err_nm),
        .mem_addr(mem_addr_nm), .mem_datai(mem_datai_nm), .mem_datao(mem_datao_nm),
        .mem_ce(mem_ce_nm), .mem_wstb(mem_wstb_nm)
    );

    // Memory model: combinational read, byte-lane write on the rising edge.
    assign mem_datao    = mem[mem_addr[7:0]];
    assign mem_datao_nm = mem_nm[mem_addr_nm[7:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]    <= 32'd0;
                mem_nm[i] <= 32'd0;
            end
        end else begin
            if (mem_ce) begin
                for (int i = 0; i < 4; i++)
                    if (mem_wstb[i]) mem[mem_addr[7:0]][8*i +: 8] <= mem_datai[8*i +: 8];
            end
            if (mem_ce_nm) begin
                for (int i = 0; i < 4; i++)
                    if (mem_wstb_nm[i]) mem_nm[mem_addr_nm[7:0]][8*i +: 8] <= mem_datai_nm[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = r; we = w; funct3 = f; addr = a; wdata = d;
        #2;
    endtask

    task automatic hold();
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; mem_clr = 1'b1; req = 1'b1; req_nm = 1'b0;
        we = 1'b1; funct3 = 3'd2; addr = 32'h100; wdata = 32'hDEADBEEF;
        @(negedge clk);
        #2;
        chk("rst_ce",    {31'd0, mem_ce},   32'd0);
        chk("rst_wstb",  {28'd0, mem_wstb}, 32'd0);
        chk("rst_stall", {31'd0, stall},    32'd0);
        chk("rst_done",  {31'd0, done},     32'd0);
        chk("rst_err",   {31'd0, err},      32'd0);
        chk("rst_rdata", rdata,             32'd0);
        chk("rst_addr",  {2'd0, mem_addr},  32'd0);
        chk("rst_datai", mem_datai,         32'd0);
        rst_n = 1'b1; mem_clr = 1'b0; req = 1'b0;

        drive(1'b0, 1'b0, 3'd2, 32'h100, 32'd0);
        chk("idle_ce",   {31'd0, mem_ce}, 32'd0);
        chk("idle_done", {31'd0, done},   32'd0);
        chk("idle_stall",{31'd0, stall},  32'd0);

        // Aligned store and sub-word loads
        drive(1'b1, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        chk("sw_wstb",  {28'd0, mem_wstb}, 32'hF);
        chk("sw_addr",  {2'd0, mem_addr},  32'h40);
        chk("sw_datai", mem_datai,         32'hDEADBEEF);
        chk("sw_done",  {31'd0, done},     32'd1);
        chk("sw_stall", {31'd0, stall},    32'd0);
        drive(1'b1, 1'b0, 3'd0, 32'h101, 32'd0);
        chk("lb_rdata", rdata,             32'hFFFFFFBE);
        chk("lb_done",  {31'd0, done},     32'd1);
        chk("lb_wstb",  {28'd0, mem_wstb}, 32'd0);
        drive(1'b1, 1'b0, 3'd4, 32'h101, 32'd0);
        chk("lbu_rdata", rdata, 32'h000000BE);
        drive(1'b1, 1'b0, 3'd5, 32'h102, 32'd0);
        chk("lhu_rdata", rdata, 32'h0000DEAD);
        chk("lhu_done",  {31'd0, done}, 32'd1);

        drive(1'b1, 1'b1, 3'd1, 32'h102, 32'h00001234);
        chk("sh_wstb",  {28'd0, mem_wstb}, 32'hC);
        chk("sh_datai", mem_datai,         32'h12340000);
        drive(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        chk("sh_readback", rdata, 32'h1234BEEF);

        // Split word store and load
        drive(1'b1, 1'b1, 3'd2, 32'h201, 32'hAABBCCDD);
        chk("ssw1_stall", {31'd0, stall},    32'd1);
        chk("ssw1_done",  {31'd0, done},     32'd0);
        chk("ssw1_addr",  {2'd0, mem_addr},  32'h80);
        chk("ssw1_wstb",  {28'd0, mem_wstb}, 32'hE);
        chk("ssw1_datai", mem_datai,         32'hBBCCDD00);
        hold();
        chk("ssw2_addr",  {2'd0, mem_addr},  32'h81);
        chk("ssw2_wstb",  {28'd0, mem_wstb}, 32'h1);
        chk("ssw2_datai", mem_datai,         32'h000000AA);
        chk("ssw2_done",  {31'd0, done},     32'd1);
        chk("ssw2_stall", {31'd0, stall},    32'd0);
        drive(1'b1, 1'b0, 3'd2, 32'h201, 32'd0);
        chk("slw1_stall", {31'd0, stall}, 32'd1);
        chk("slw1_rdata", rdata,          32'd0);
        hold();
        chk("slw2_done",  {31'd0, done}, 32'd1);
        chk("slw2_rdata", rdata,         32'hAABBCCDD);
        chk("mem_w80",    mem[8'h80],    32'hBBCCDD00);
        chk("mem_w81",    mem[8'h81],    32'h000000AA);

        // Halfword split load wrapping from the last word to word 0
        drive(1'b1, 1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000080);
        chk("sbtop_wstb", {28'd0, mem_wstb}, 32'h8);
        chk("sbtop_addr", {2'd0, mem_addr},  32'h3FFFFFFF);
        chk("sbtop_datai", mem_datai,        32'h80000000);
        drive(1'b1, 1'b1, 3'd0, 32'h0, 32'h00000001);
        drive(1'b1, 1'b0, 3'd1, 32'hFFFFFFFF, 32'd0);
        chk("wrap1_addr", {2'd0, mem_addr}, 32'h3FFFFFFF);
        chk("wrap1_stall", {31'd0, stall},  32'd1);
        hold();
        chk("wrap2_addr",  {2'd0, mem_addr}, 32'd0);
        chk("wrap2_rdata", rdata,            32'h00000180);

        // Split halfword bytes 0x80,0xFF at 0x203, then extended loads
        drive(1'b1, 1'b1, 3'd1, 32'h203, 32'h0000FF80);
        chk("ssh1_wstb", {28'd0, mem_wstb}, 32'h8);
        hold();
        chk("ssh2_wstb",  {28'd0, mem_wstb}, 32'h1);
        chk("ssh2_datai", mem_datai,         32'h000000FF);
        drive(1'b1, 1'b0, 3'd5, 32'h203, 32'd0);
        hold();
        chk("lhu_split", rdata, 32'h0000FF80);
        drive(1'b1, 1'b0, 3'd1, 32'h203, 32'd0);
        hold();
        chk("lh_split", rdata, 32'hFFFFFF80);

        // Illegal width codes
        drive(1'b1, 1'b0, 3'd3, 32'h100, 32'd0);
        chk("ill_ld_err",   {31'd0, err},    32'd1);
        chk("ill_ld_done",  {31'd0, done},   32'd1);
        chk("ill_ld_ce",    {31'd0, mem_ce}, 32'd0);
        chk("ill_ld_rdata", rdata,           32'd0);
        chk("ill_ld_stall", {31'd0, stall},  32'd0);
        drive(1'b1, 1'b1, 3'd4, 32'h100, 32'h55555555);
        chk("ill_st_err",  {31'd0, err},      32'd1);
        chk("ill_st_wstb", {28'd0, mem_wstb}, 32'd0);
        drive(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        chk("ill_nochange", rdata, 32'h1234BEEF);

        // Misaligned access rejected when splitting is disabled
        req = 1'b0;
        @(negedge clk);
        req_nm = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h0; wdata = 32'h11223344;
        #2;
        chk("nm_sw_done", {31'd0, done_nm}, 32'd1);
        chk("nm_sw_err",  {31'd0, err_nm},  32'd0);
        @(negedge clk);
        addr = 32'h2; wdata = 32'h55667788;
        #2;
        chk("nm_mis_err",  {31'd0, err_nm},      32'd1);
        chk("nm_mis_done", {31'd0, done_nm},     32'd1);
        chk("nm_mis_ce",   {31'd0, mem_ce_nm},   32'd0);
        chk("nm_mis_stall",{31'd0, stall_nm},    32'd0);
        @(negedge clk);
        req_nm = 1'b0;
        #2;
        chk("nm_mem_kept", mem_nm[0], 32'h11223344);
        chk("main_idle",   {31'd0, done}, 32'd0);

        // Reset during the second half of a split store
        drive(1'b1, 1'b1, 3'd2, 32'h303, 32'h99887766);
        chk("rs1_stall", {31'd0, stall},    32'd1);
        chk("rs1_wstb",  {28'd0, mem_wstb}, 32'h8);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("rs2_ce",    {31'd0, mem_ce},   32'd0);
        chk("rs2_wstb",  {28'd0, mem_wstb}, 32'd0);
        chk("rs2_done",  {31'd0, done},     32'd0);
        @(negedge clk);
        rst_n = 1'b1; req = 1'b0;
        #2;
        chk("rs3_stall", {31'd0, stall}, 32'd0);
        chk("rs3_done",  {31'd0, done},  32'd0);
        chk("rs_memC0",  mem[8'hC0],     32'h66000000);
        chk("rs_memC1",  mem[8'hC1],     32'd0);
        drive(1'b1, 1'b0, 3'd2, 32'h300, 32'd0);
        chk("rs_idle_lw", {31'd0, done}, 32'd1);
        chk("rs_lw_rdata", rdata,        32'h66000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
